// File: rtl/button_debouncer_pkg.sv
// Shared definitions for the push-button debouncer.
// Contents: per-channel state enum, board button index constants and a
// width helper for the auto-repeat counter.
// Optional feature macro: AUTO_REPEAT_EN (uses rep_cnt_width).
package btn_pkg;

    // Per-channel debounce state
    typedef enum logic [1:0] {
        UP     = 2'd0,
        ARM_DN = 2'd1,
        DOWN   = 2'd2,
        ARM_UP = 2'd3
    } btn_state_e;

    // Bit positions of the board buttons within btn_raw / btn_level
    localparam int unsigned BTN_UP    = 0;
    localparam int unsigned BTN_DOWN  = 1;
    localparam int unsigned BTN_LEFT  = 2;
    localparam int unsigned BTN_RIGHT = 3;
    localparam int unsigned BTN_SEL   = 4;

    // Width needed to count up to the larger of the two repeat intervals
    function automatic int unsigned rep_cnt_width(input int unsigned delay,
                                                  input int unsigned period);
        int unsigned m;
        m = (delay > period) ? delay : period;
        return (m < 2) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/button_debouncer_channel.sv
// One debounce channel: 2-flop synchroniser, 4-state debounce FSM with a
// stability counter, registered level / press / release outputs.
// Ports:
//   clk_in      - system clock
//   rst         - asynchronous active-high reset
//   tick_in     - sampling enable (FSM and counters advance only on it)
//   btn_raw     - raw asynchronous pin, 1 = pressed
//   btn_level   - debounced level
//   btn_press   - one-cycle pulse on accepted press (and auto-repeat)
//   btn_release - one-cycle pulse on accepted release
// Macro AUTO_REPEAT_EN adds press auto-repeat while the button is held.
module debounce_channel
    import btn_pkg::*;
#(
    parameter int unsigned STABLE_TICKS  = 4,
    parameter int unsigned CNT_W         = 8,
    parameter int unsigned REPEAT_DELAY  = 50,
    parameter int unsigned REPEAT_PERIOD = 10
) (
    input  logic clk_in,
    input  logic rst,
    input  logic tick_in,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             w_samp;
    btn_state_e       r_state;
    btn_state_e       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_level;
    logic             r_press;
    logic             r_release;
    logic             w_level_nxt;
    logic             w_press_nxt;
    logic             w_release_nxt;
    logic             w_press_d;

    assign w_samp = r_sync2;

    // Next-state logic: advance only on ticks, pulses default low
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_level_nxt   = r_level;
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;
        if (tick_in) begin
            case (r_state)
                UP: begin
                    if (w_samp) begin
                        if (STABLE_TICKS == 1) begin
                            w_state_nxt = DOWN;
                            w_level_nxt = 1'b1;
                            w_press_nxt = 1'b1;
                        end else begin
                            w_state_nxt = ARM_DN;
                            w_cnt_nxt   = CNT_W'(1);
                        end
                    end
                end
                ARM_DN: begin
                    if (!w_samp) begin
                        w_state_nxt = UP;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == CNT_LAST) begin
                        w_state_nxt = DOWN;
                        w_cnt_nxt   = '0;
                        w_level_nxt = 1'b1;
                        w_press_nxt = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                DOWN: begin
                    if (!w_samp) begin
                        if (STABLE_TICKS == 1) begin
                            w_state_nxt   = UP;
                            w_level_nxt   = 1'b0;
                            w_release_nxt = 1'b1;
                        end else begin
                            w_state_nxt = ARM_UP;
                            w_cnt_nxt   = CNT_W'(1);
                        end
                    end
                end
                ARM_UP: begin
                    if (w_samp) begin
                        w_state_nxt = DOWN;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == CNT_LAST) begin
                        w_state_nxt   = UP;
                        w_cnt_nxt     = '0;
                        w_level_nxt   = 1'b0;
                        w_release_nxt = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = UP;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

`ifdef AUTO_REPEAT_EN
    localparam int unsigned REP_W = rep_cnt_width(REPEAT_DELAY, REPEAT_PERIOD);

    logic [REP_W-1:0] r_rep;
    logic [REP_W-1:0] w_rep_nxt;
    logic [REP_W-1:0] w_rep_target;
    logic             r_rep_phase;
    logic             w_rep_phase_nxt;
    logic             w_rep_fire;

    // Repeat timer: first interval is the delay, later ones the period.
    // Leaving the held states clears it, so it never fires with a release.
    always_comb begin
        w_rep_nxt       = r_rep;
        w_rep_phase_nxt = r_rep_phase;
        w_rep_fire      = 1'b0;
        w_rep_target    = r_rep_phase ? REP_W'(REPEAT_PERIOD) : REP_W'(REPEAT_DELAY);
        if (w_state_nxt == UP || w_state_nxt == ARM_DN) begin
            w_rep_nxt       = '0;
            w_rep_phase_nxt = 1'b0;
        end else if (tick_in && (r_state == DOWN || r_state == ARM_UP)) begin
            if (r_rep + REP_W'(1) == w_rep_target) begin
                w_rep_fire      = 1'b1;
                w_rep_nxt       = '0;
                w_rep_phase_nxt = 1'b1;
            end else begin
                w_rep_nxt = r_rep + REP_W'(1);
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_rep       <= '0;
            r_rep_phase <= 1'b0;
        end else begin
            r_rep       <= w_rep_nxt;
            r_rep_phase <= w_rep_phase_nxt;
        end
    end

    assign w_press_d = w_press_nxt | w_rep_fire;
`else
    logic w_unused_rep;
    assign w_unused_rep = ^{REPEAT_DELAY, REPEAT_PERIOD};
    assign w_press_d    = w_press_nxt;
`endif

    // Synchroniser runs every cycle; FSM registers follow next-state logic
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_state   <= UP;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_sync1   <= btn_raw;
            r_sync2   <= r_sync1;
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_level   <= w_level_nxt;
            r_press   <= w_press_d;
            r_release <= w_release_nxt;
        end
    end

    assign btn_level   = r_level;
    assign btn_press   = r_press;
    assign btn_release = r_release;

endmodule

// File: rtl/button_debouncer.sv
// Debounces NUM_BTN raw push-buttons into clean levels plus one-cycle
// press/release pulses, sampling on the divider's tick_in enable.
// Ports:
//   clk_in      - system clock
//   rst         - asynchronous active-high reset
//   tick_in     - sampling enable pulse, synchronous to clk_in
//   btn_raw     - raw asynchronous button pins, 1 = pressed
//   btn_level   - debounced levels
//   btn_press   - one-cycle press pulses
//   btn_release - one-cycle release pulses
// Macro AUTO_REPEAT_EN enables press auto-repeat in every channel.
module button_debouncer
    import btn_pkg::*;
#(
    parameter int unsigned NUM_BTN       = 5,
    parameter int unsigned STABLE_TICKS  = 4,
    parameter int unsigned CNT_W         = 8,
    parameter int unsigned REPEAT_DELAY  = 50,
    parameter int unsigned REPEAT_PERIOD = 10
) (
    input  logic               clk_in,
    input  logic               rst,
    input  logic               tick_in,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release
);

    // One fully independent channel per button
    for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
        debounce_channel #(
            .STABLE_TICKS (STABLE_TICKS),
            .CNT_W        (CNT_W),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_PERIOD(REPEAT_PERIOD)
        ) u_ch (
            .clk_in     (clk_in),
            .rst        (rst),
            .tick_in    (tick_in),
            .btn_raw    (btn_raw[g]),
            .btn_level  (btn_level[g]),
            .btn_press  (btn_press[g]),
            .btn_release(btn_release[g])
        );
    end

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer. Main instance: STABLE_TICKS=4, tick every 10
// cycles (ticks at posedges 10, 20, ...). Second instance: STABLE_TICKS=1,
// tick tied high, repeat delay 5 / period 2 (repeat only with AUTO_REPEAT_EN).
// Expected output events (cycle, level, press, release) are queued by the
// stimulus; monitors pop and compare whenever a pulse or level change shows.
module tb_button_debouncer;

    localparam int unsigned NB = 5;

    typedef struct packed {
        int          cyc;
        logic [NB-1:0] level;
        logic [NB-1:0] press;
        logic [NB-1:0] rel;
    } exp_t;

    logic          clk_in = 1'b0;
    logic          rst;
    logic          tick_in;
    logic          tick_b;
    logic [NB-1:0] btn_raw;
    logic [NB-1:0] btn_level, btn_press, btn_release;
    logic [NB-1:0] btn_raw_b;
    logic [NB-1:0] lvl_b, prs_b, rel_b;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t qm[$];
    exp_t qb[$];

    button_debouncer #(
        .NUM_BTN(NB), .STABLE_TICKS(4), .CNT_W(8),
        .REPEAT_DELAY(200), .REPEAT_PERIOD(10)
    ) dut (
        .clk_in(clk_in), .rst(rst), .tick_in(tick_in), .btn_raw(btn_raw),
        .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release)
    );

    button_debouncer #(
        .NUM_BTN(NB), .STABLE_TICKS(1), .CNT_W(8),
        .REPEAT_DELAY(5), .REPEAT_PERIOD(2)
    ) dut_b (
        .clk_in(clk_in), .rst(rst), .tick_in(tick_b), .btn_raw(btn_raw_b),
        .btn_level(lvl_b), .btn_press(prs_b), .btn_release(rel_b)
    );

    initial forever #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    // Tick visible to posedges that are multiples of 10
    initial begin
        tick_in = 1'b0;
        forever begin
            @(negedge clk_in);
            tick_in = ((cyc + 1) % 10 == 0);
        end
    end

    task automatic check_vec(input string name, input logic [NB-1:0] got,
                             input logic [NB-1:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %b want %b (cyc %0d)", name, got, want, cyc);
        end
    endtask

    function automatic void cmp_event(input string name, input exp_t got, input exp_t want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got cyc=%0d lvl=%b prs=%b rel=%b, want cyc=%0d lvl=%b prs=%b rel=%b",
                     name, got.cyc, got.level, got.press, got.rel,
                     want.cyc, want.level, want.press, want.rel);
        end
    endfunction

    function automatic void unexpected(input string name, input exp_t got);
        n_checks++;
        n_fail++;
        $display("FAIL %s_unexpected: got cyc=%0d lvl=%b prs=%b rel=%b, want no event",
                 name, got.cyc, got.level, got.press, got.rel);
    endfunction

    // Main-instance monitor
    initial begin
        logic [NB-1:0] prev;
        exp_t got;
        prev = '0;
        forever begin
            @(negedge clk_in);
            if (rst) begin
                prev = btn_level;
            end else begin
                if (btn_press != '0 || btn_release != '0 || btn_level != prev) begin
                    got = exp_t'{cyc, btn_level, btn_press, btn_release};
                    if (qm.size() == 0) unexpected("main", got);
                    else cmp_event("main_event", got, qm.pop_front());
                end
                prev = btn_level;
            end
        end
    end

    // Fast-instance monitor
    initial begin
        logic [NB-1:0] prev;
        exp_t got;
        prev = '0;
        forever begin
            @(negedge clk_in);
            if (rst) begin
                prev = lvl_b;
            end else begin
                if (prs_b != '0 || rel_b != '0 || lvl_b != prev) begin
                    got = exp_t'{cyc, lvl_b, prs_b, rel_b};
                    if (qb.size() == 0) unexpected("fast", got);
                    else cmp_event("fast_event", got, qb.pop_front());
                end
                prev = lvl_b;
            end
        end
    end

    // Stimulus changes land 2 time units after the negedge of cycle n
    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk_in);
        #2;
    endtask

    task automatic push_m(input int c, input logic [NB-1:0] l, input logic [NB-1:0] p,
                          input logic [NB-1:0] r);
        qm.push_back(exp_t'{c, l, p, r});
    endtask

    task automatic push_b(input int c, input logic [NB-1:0] l, input logic [NB-1:0] p,
                          input logic [NB-1:0] r);
        qb.push_back(exp_t'{c, l, p, r});
    endtask

    initial begin
        rst       = 1'b1;
        btn_raw   = '0;
        btn_raw_b = '0;
        tick_b    = 1'b1;

        wait_cyc(2);
        check_vec("reset_level", btn_level, '0);
        check_vec("reset_press", btn_press, '0);
        check_vec("reset_release", btn_release, '0);
        wait_cyc(3);
        rst = 1'b0;

        // Reset in the middle of a press count: count restarts from scratch
        wait_cyc(5);   btn_raw = 5'b00001;
        wait_cyc(25);  rst = 1'b1;
        #1;
        check_vec("rst_mid_level", btn_level, '0);
        check_vec("rst_mid_press", btn_press, '0);
        wait_cyc(27);  rst = 1'b0;
        push_m(60, 5'b00001, 5'b00001, 5'b00000);

        // Clean release of ch0, clean press of ch3
        wait_cyc(65);  btn_raw = 5'b00000;
        push_m(100, 5'b00000, 5'b00000, 5'b00001);
        wait_cyc(103); btn_raw = 5'b01000;
        push_m(140, 5'b01000, 5'b01000, 5'b00000);

        // Ch4 bounce: seen high on 3 ticks, low on the 4th, then held
        wait_cyc(145); btn_raw = 5'b11000;
        wait_cyc(175); btn_raw = 5'b01000;
        wait_cyc(185); btn_raw = 5'b11000;
        push_m(220, 5'b11000, 5'b10000, 5'b00000);

        // Ch2 down, then ch1 press and ch2 release on the same ticks
        wait_cyc(225); btn_raw = 5'b11100;
        push_m(260, 5'b11100, 5'b00100, 5'b00000);
        wait_cyc(265); btn_raw = 5'b11010;
        push_m(300, 5'b11010, 5'b00010, 5'b00100);
        wait_cyc(305); btn_raw = 5'b00000;
        push_m(340, 5'b00000, 5'b00000, 5'b11010);

        // Release glitch: two low ticks, back high, then a real release
        wait_cyc(345); btn_raw = 5'b00001;
        push_m(380, 5'b00001, 5'b00001, 5'b00000);
        wait_cyc(385); btn_raw = 5'b00000;
        wait_cyc(405); btn_raw = 5'b00001;
        wait_cyc(415); btn_raw = 5'b00000;
        push_m(450, 5'b00000, 5'b00000, 5'b00001);

        // Pulse between ticks is never sampled
        wait_cyc(455); btn_raw = 5'b00100;
        wait_cyc(457); btn_raw = 5'b00000;

        // Press ch2, then reset with the level high
        wait_cyc(465); btn_raw = 5'b00100;
        push_m(500, 5'b00100, 5'b00100, 5'b00000);
        wait_cyc(503); rst = 1'b1; btn_raw = 5'b00000;
        #1;
        check_vec("rst_high_level", btn_level, '0);
        check_vec("rst_high_press", btn_press, '0);

        // Fast instance: accept on the 3rd edge after the raw change
        wait_cyc(505); rst = 1'b0; btn_raw_b = 5'b00001;
        push_b(508, 5'b00001, 5'b00001, 5'b00000);
`ifdef AUTO_REPEAT_EN
        push_b(513, 5'b00001, 5'b00001, 5'b00000);
        push_b(515, 5'b00001, 5'b00001, 5'b00000);
        push_b(517, 5'b00001, 5'b00001, 5'b00000);
        push_b(519, 5'b00001, 5'b00001, 5'b00000);
`endif
        wait_cyc(518); btn_raw_b = 5'b00000;
        push_b(521, 5'b00000, 5'b00000, 5'b00001);

        wait_cyc(560);
        n_checks++;
        if (qm.size() != 0) begin
            n_fail++;
            $display("FAIL main_missing: got %0d events outstanding, want 0", qm.size());
        end
        n_checks++;
        if (qb.size() != 0) begin
            n_fail++;
            $display("FAIL fast_missing: got %0d events outstanding, want 0", qb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
- Consumes the one-cycle enable tick from the clock-divider stage and debounces the board's raw push-buttons (up/down/left/right/select) for the tic-tac-toe game controller.
- Per button, it produces a clean level and one-cycle press/release pulses in the clk_in domain.
- Sits between the board pins and the game FSM, downstream of the divider.

Parameters:
- NUM_BTN, 5, number of independent button channels.
- STABLE_TICKS, 4, consecutive sampling ticks a new input value must persist before it is accepted (legal range 1..255).
- CNT_W, 8, width of each channel's stability counter; must hold STABLE_TICKS.
- REPEAT_DELAY, 50, ticks held before the first auto-repeat pulse; used only with AUTO_REPEAT_EN.
- REPEAT_PERIOD, 10, ticks between subsequent auto-repeat pulses; used only with AUTO_REPEAT_EN.

Ports:
- clk_in  input  1  system clock; single clock domain.
- rst  input  1  reset, asynchronous, active-high.
- tick_in  input  1  sampling enable; one clk_in-cycle pulse from the divider stage, already synchronous to clk_in.
- btn_raw  input  NUM_BTN  raw button pins, asynchronous; 1 = pressed.
- btn_level  output  NUM_BTN  debounced state; 1 = pressed.
- btn_press  output  NUM_BTN  one-cycle pulse on each accepted 0->1 transition.
- btn_release  output  NUM_BTN  one-cycle pulse on each accepted 1->0 transition.

Behaviour:
- Clock and reset: one clock, clk_in; reset rst is asynchronous and active-high.
- Reset: every output, synchroniser flop, counter and state register is cleared asynchronously.
  - btn_level = 0, btn_press = 0, btn_release = 0.
  - No pulses are emitted because of reset.
  - Reset mid-count discards the partial count.
- Synchroniser: each btn_raw bit passes through a 2-flop synchroniser clocked every clk_in cycle, independent of tick_in. Its output is called samp.
- Channel FSM states (per channel):
  - UP: level 0, counter 0.
  - ARM_DN: level 0, counting toward press.
  - DOWN: level 1, counter 0.
  - ARM_UP: level 1, counting toward release.
- State and counter change only on clk_in edges where tick_in = 1; otherwise they hold.
- UP, on tick:
  - samp = 1 -> counter = 1, go to ARM_DN.
  - If STABLE_TICKS = 1, go directly to DOWN instead and pulse press.
- ARM_DN, on tick:
  - samp = 0 -> counter = 0, go to UP (glitch rejected).
  - samp = 1 and counter = STABLE_TICKS-1 -> go to DOWN, btn_level <= 1, btn_press = 1 for exactly that one cycle.
  - Otherwise counter++.
- DOWN and ARM_UP mirror UP and ARM_DN with samp inverted; the completing transition pulses btn_release.
- Pulse timing: press and release pulses are registered and assert in the same cycle that btn_level changes. They deassert the next clk_in cycle regardless of tick_in.
- Latency: from a stable raw change to the btn_level change is 2 clk_in cycles (synchroniser) plus STABLE_TICKS ticks, measured to the tick edge that completes the count.
- Independence: channels are fully independent. Simultaneous press and release pulses on different bits in the same cycle are legal.
- tick_in held constantly high is legal and makes the block count every cycle (used for fast simulation).
- No counter wrap: the counter never exceeds STABLE_TICKS-1.

Optional Feature:
- Macro: AUTO_REPEAT_EN.
- Defined:
  - Each channel has a repeat counter running in DOWN on ticks.
  - After REPEAT_DELAY ticks held, btn_press pulses again, then every REPEAT_PERIOD ticks while the channel stays in DOWN or ARM_UP.
  - Leaving to UP clears the repeat counter.
  - A repeat pulse is never emitted in the same cycle as a release pulse.
- Undefined: no repeat logic; btn_press pulses only on accepted 0->1 transitions; the REPEAT_* parameters are ignored.

Decomposition:
- Shared package btn_pkg contains:
  - channel state enum {UP, ARM_DN, DOWN, ARM_UP};
  - button index constants BTN_UP = 0, BTN_DOWN = 1, BTN_LEFT = 2, BTN_RIGHT = 3, BTN_SEL = 4.
- Sub-module debounce_channel: one synchroniser, FSM and counter, plus the repeat logic under the macro. It is instantiated NUM_BTN times by a generate loop in button_debouncer.

Test Plan:
- Setup: STABLE_TICKS = 4; tick_in pulses every 10 cycles.
- Reset: assert rst mid-ARM_DN with btn_raw = 5'b00001 -> all outputs 0 immediately. After release, btn_level[0] rises only after 4 fresh ticks, not earlier.
- Clean press: raise btn_raw[0] and hold -> btn_level[0] rises at the 4th tick edge after synchroniser delay; btn_press[0] is high exactly 1 cycle; btn_release stays 0.
- Bounce: toggle btn_raw[4] so samp is seen high on 3 ticks then low on the 4th -> btn_level[4] stays 0 and no pulse. Then hold high for 4 ticks -> one press pulse.
- Simultaneous: channel 1 pressed and channel 2 released, stable on the same ticks -> btn_press[1] and btn_release[2] pulse in the same cycle.
- STABLE_TICKS = 1 with tick_in tied high: raw 0->1 -> level rises 3 cycles after the raw edge (2 synchroniser + 1), with a single press pulse.
- AUTO_REPEAT_EN with REPEAT_DELAY = 5, REPEAT_PERIOD = 2: hold btn_raw[3] -> press at acceptance, then at +5 ticks, +7, +9. Release -> btn_release[3] pulses and repeats stop.
